// File: rtl/sha256_block_feeder.sv
// Splits a 32-bit word stream into padded 512-bit SHA-256 blocks and chains them through an external core.
// Define SHA256_DOUBLE_EN to hash the first digest a second time (Bitcoin double SHA-256).
module sha256_block_feeder #(
    parameter int MAX_WORDS = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              msg_valid,
    input  logic [31:0]       msg_word,
    input  logic              msg_last,
    output logic              msg_ready,
    output logic              core_start,
    output logic [15:0][31:0] core_message,
    output logic [7:0][31:0]  core_hin,
    input  logic [7:0][31:0]  core_hout,
    input  logic              core_done,
    output logic [7:0][31:0]  digest,
    output logic              digest_valid,
    input  logic              digest_ready,
    output logic              msg_err
);

    localparam int TW = $clog2(MAX_WORDS + 1);
    localparam logic [7:0][31:0] IV = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

    typedef enum logic [2:0] {
        IDLE, FILL, PAD, ISSUE, WAIT_LO, WAIT_HI, EXTRA, OUT
    } stateT;

    stateT             r_state, w_nextState;
    logic [15:0][31:0] r_block;
    logic [7:0][31:0]  r_chain;
    logic [7:0][31:0]  r_digest;
    logic [4:0]        r_wptr;
    logic [4:0]        r_markerPos;
    logic [TW-1:0]     r_total;
    logic              r_more;
    logic              r_extra;
    logic              r_markerDone;
    logic              r_alive;
    logic              r_digestValid;
    logic              r_msgErr;
`ifdef SHA256_DOUBLE_EN
    logic              r_second;
`endif

    logic [TW-1:0]     w_totalNext;
    logic              w_errHit;
    logic              w_lastEff;
    logic              w_accept;
    logic              w_lenFits;
    logic [63:0]       w_bitLen;
    logic [31:0]       w_padWord;

    assign w_totalNext = (r_state == IDLE) ? TW'(1) : r_total + TW'(1);
    assign w_errHit    = !msg_last && (w_totalNext == TW'(MAX_WORDS));
    assign w_lastEff   = msg_last || w_errHit;
    assign w_accept    = msg_valid && msg_ready;
    assign w_bitLen    = 64'(r_total) << 5;
    // Length only fits in this block when the marker left words 14/15 free.
    assign w_lenFits   = (r_markerPos <= 5'd13);

    always_comb begin
        w_padWord = 32'h0;
        if (r_wptr == r_markerPos)
            w_padWord = 32'h80000000;
        else if (w_lenFits && r_wptr == 5'd14)
            w_padWord = w_bitLen[63:32];
        else if (w_lenFits && r_wptr == 5'd15)
            w_padWord = w_bitLen[31:0];
    end

    assign core_message = r_block;
    assign core_hin     = r_chain;
    assign digest       = r_digest;
    assign digest_valid = r_digestValid;
    assign msg_err      = r_msgErr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        msg_ready   = 1'b0;
        core_start  = 1'b0;
        case (r_state)
            IDLE, FILL: begin
                msg_ready = r_alive && (r_wptr < 5'd16);
                if (w_accept) begin
                    if (w_lastEff)
                        w_nextState = PAD;
                    else if (r_wptr == 5'd15)
                        w_nextState = ISSUE;
                    else
                        w_nextState = FILL;
                end
            end
            PAD: begin
                if (r_wptr >= 5'd15)
                    w_nextState = ISSUE;
            end
            ISSUE: begin
                core_start = core_done;
                if (core_done)
                    w_nextState = WAIT_LO;
            end
            WAIT_LO: begin
                if (!core_done)
                    w_nextState = WAIT_HI;
            end
            WAIT_HI: begin
                if (core_done) begin
                    if (r_more)
                        w_nextState = FILL;
                    else if (r_extra)
                        w_nextState = EXTRA;
                    else begin
`ifdef SHA256_DOUBLE_EN
                        w_nextState = r_second ? OUT : ISSUE;
`else
                        w_nextState = OUT;
`endif
                    end
                end
            end
            EXTRA: w_nextState = ISSUE;
            OUT: begin
                if (digest_ready)
                    w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_block       <= '0;
            r_chain       <= '0;
            r_digest      <= '0;
            r_wptr        <= '0;
            r_markerPos   <= '0;
            r_total       <= '0;
            r_more        <= 1'b0;
            r_extra       <= 1'b0;
            r_markerDone  <= 1'b0;
            r_alive       <= 1'b0;
            r_digestValid <= 1'b0;
            r_msgErr      <= 1'b0;
`ifdef SHA256_DOUBLE_EN
            r_second      <= 1'b0;
`endif
        end else begin
            r_alive <= 1'b1;
            case (r_state)
                IDLE, FILL: begin
                    if (w_accept) begin
                        r_block[r_wptr[3:0]] <= msg_word;
                        r_wptr  <= r_wptr + 5'd1;
                        r_total <= w_totalNext;
                        if (r_state == IDLE) begin
                            r_chain      <= IV;
                            r_msgErr     <= w_errHit;
                            r_more       <= 1'b0;
                            r_extra      <= 1'b0;
                            r_markerDone <= 1'b0;
`ifdef SHA256_DOUBLE_EN
                            r_second     <= 1'b0;
`endif
                        end else if (w_errHit) begin
                            r_msgErr <= 1'b1;
                        end
                        if (w_lastEff)
                            r_markerPos <= r_wptr + 5'd1;
                        else if (r_wptr == 5'd15)
                            r_more <= 1'b1;
                    end
                end
                PAD: begin
                    if (r_wptr != 5'd16) begin
                        r_block[r_wptr[3:0]] <= w_padWord;
                        r_wptr <= r_wptr + 5'd1;
                    end
                    if (r_wptr >= 5'd15) begin
                        r_extra      <= !w_lenFits;
                        r_markerDone <= (r_markerPos < 5'd16);
                    end
                end
                WAIT_HI: begin
                    if (core_done) begin
                        r_chain <= core_hout;
                        if (r_more) begin
                            r_wptr <= '0;
                            r_more <= 1'b0;
                        end else if (!r_extra) begin
`ifdef SHA256_DOUBLE_EN
                            if (!r_second) begin
                                // Second pass hashes the 256-bit first digest as a one-block message.
                                r_block       <= '0;
                                r_block[7:0]  <= core_hout;
                                r_block[8]    <= 32'h80000000;
                                r_block[15]   <= 32'h00000100;
                                r_chain       <= IV;
                                r_second      <= 1'b1;
                            end else begin
                                r_digest      <= core_hout;
                                r_digestValid <= 1'b1;
                            end
`else
                            r_digest      <= core_hout;
                            r_digestValid <= 1'b1;
`endif
                        end
                    end
                end
                EXTRA: begin
                    r_block <= '0;
                    if (!r_markerDone)
                        r_block[0] <= 32'h80000000;
                    r_block[14] <= w_bitLen[63:32];
                    r_block[15] <= w_bitLen[31:0];
                    r_extra     <= 1'b0;
                end
                OUT: begin
                    if (digest_ready) begin
                        r_digestValid <= 1'b0;
                        r_wptr        <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_block_feeder.sv
// Self-checking bench for sha256_block_feeder with a behavioural SHA-256 core and a padding/hash reference model.
module tb_sha256_block_feeder;

    localparam int MAX_WORDS = 20;
`ifdef SHA256_DOUBLE_EN
    localparam int DOUBLE = 1;
`else
    localparam int DOUBLE = 0;
`endif

    typedef logic [7:0][31:0]  hashT;
    typedef logic [15:0][31:0] blockT;

    localparam hashT IV = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        coreRst = 1'b1;
    logic        msg_valid = 1'b0;
    logic [31:0] msg_word = '0;
    logic        msg_last = 1'b0;
    logic        msg_ready;
    logic        core_start;
    blockT       core_message;
    hashT        core_hin;
    hashT        core_hout;
    logic        core_done;
    hashT        digest;
    logic        digest_valid;
    logic        digest_ready = 1'b0;
    logic        msg_err;

    int compareCount = 0;
    int mismatchCount = 0;
    int protoErrors = 0;

    blockT       logMsg[$];
    hashT        logHin[$];
    blockT       expBlocks[$];
    hashT        expHins[$];
    hashT        expDigest;
    logic [31:0] tbWords[$];

    always #5 clk = ~clk;

    sha256_block_feeder #(.MAX_WORDS(MAX_WORDS)) dut (
        .clk(clk), .reset(reset),
        .msg_valid(msg_valid), .msg_word(msg_word), .msg_last(msg_last), .msg_ready(msg_ready),
        .core_start(core_start), .core_message(core_message), .core_hin(core_hin),
        .core_hout(core_hout), .core_done(core_done),
        .digest(digest), .digest_valid(digest_valid), .digest_ready(digest_ready),
        .msg_err(msg_err)
    );

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Full SHA-256 compression including the final feed-forward addition.
    function automatic hashT sha256Compress(input hashT h, input blockT m);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
        hashT r;
        for (int i = 0; i < 16; i++) w[i] = m[i];
        for (int i = 16; i < 64; i++)
            w[i] = w[i-16] + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3))
                 + w[i-7] + (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10));
        a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
        for (int i = 0; i < 64; i++) begin
            t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        r[0] = h[0] + a; r[1] = h[1] + b; r[2] = h[2] + c; r[3] = h[3] + d;
        r[4] = h[4] + e; r[5] = h[5] + f; r[6] = h[6] + g; r[7] = h[7] + hh;
        return r;
    endfunction

    // Core model: takes start one cycle late, busy for a random number of cycles.
    logic  corePending;
    logic  coreAborted;
    int    coreCount;
    blockT coreMsg;
    hashT  coreHin;
    always @(posedge clk or posedge coreRst) begin
        if (coreRst) begin
            core_done   <= 1'b1;
            core_hout   <= '0;
            corePending <= 1'b0;
            coreAborted <= 1'b0;
            coreCount   <= 0;
        end else begin
            if (reset)
                coreAborted <= 1'b1;
            if (core_start) begin
                if (!core_done || corePending) protoErrors++;
                corePending <= 1'b1;
                coreAborted <= 1'b0;
                coreMsg     <= core_message;
                coreHin     <= core_hin;
                logMsg.push_back(core_message);
                logHin.push_back(core_hin);
            end
            if (corePending) begin
                corePending <= 1'b0;
                core_done   <= 1'b0;
                coreCount   <= $urandom_range(1, 5);
            end else if (!core_done) begin
                if (!coreAborted && !reset && (core_message !== coreMsg || core_hin !== coreHin))
                    protoErrors++;
                if (coreCount == 0) begin
                    core_hout <= sha256Compress(coreHin, coreMsg);
                    core_done <= 1'b1;
                end else begin
                    coreCount <= coreCount - 1;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference: standard SHA-256 padding on the word list, chained from IV.
    task automatic computeModel(input int n);
        logic [31:0] q[$];
        hashT  h;
        blockT b;
        expBlocks.delete();
        expHins.delete();
        for (int i = 0; i < n; i++) q.push_back(tbWords[i]);
        q.push_back(32'h80000000);
        while (q.size() % 16 != 14) q.push_back(32'h0);
        q.push_back(32'h0);
        q.push_back(32'(n * 32));
        h = IV;
        for (int k = 0; k < q.size() / 16; k++) begin
            for (int j = 0; j < 16; j++) b[j] = q[16*k + j];
            expBlocks.push_back(b);
            expHins.push_back(h);
            h = sha256Compress(h, b);
        end
        if (DOUBLE != 0) begin
            b = '0;
            for (int j = 0; j < 8; j++) b[j] = h[j];
            b[8]  = 32'h80000000;
            b[15] = 32'h00000100;
            expBlocks.push_back(b);
            expHins.push_back(IV);
            h = sha256Compress(IV, b);
        end
        expDigest = h;
    endtask

    task automatic fillRandom(input int n);
        tbWords.delete();
        for (int i = 0; i < n; i++) tbWords.push_back($urandom);
    endtask

    task automatic applyStimulus(input int n, input bit giveLast);
        int waitCycles;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                msg_valid = 1'b0;
                @(negedge clk);
            end
            msg_valid = 1'b1;
            msg_word  = tbWords[i];
            msg_last  = giveLast && (i == n - 1);
            waitCycles = 0;
            while (msg_ready !== 1'b1 && waitCycles < 2000) begin
                @(negedge clk);
                waitCycles++;
            end
            if (waitCycles >= 2000) begin
                checkOutput("sendTimeout", 0, 1);
                msg_valid = 1'b0;
                msg_last  = 1'b0;
                return;
            end
            @(posedge clk);
        end
        @(negedge clk);
        msg_valid = 1'b0;
        msg_last  = 1'b0;
    endtask

    task automatic receiveDigest(input string name, input int hold, input bit expErr);
        int   waitCycles = 0;
        int   bad = 0;
        hashT held;
        while (digest_valid !== 1'b1 && waitCycles < 2000) begin
            @(negedge clk);
            waitCycles++;
        end
        if (waitCycles >= 2000) begin
            checkOutput({name, "_digestTimeout"}, 0, 1);
            return;
        end
        held = digest;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (digest !== held || digest_valid !== 1'b1 || msg_ready !== 1'b0) bad++;
        end
        checkOutput({name, "_holdStable"}, bad, 0);
        checkOutput({name, "_digest"}, digest, expDigest);
        checkOutput({name, "_msgErr"}, msg_err, expErr);
        digest_ready = 1'b1;
        @(negedge clk);
        digest_ready = 1'b0;
        checkOutput({name, "_validDrop"}, digest_valid, 0);
    endtask

    task automatic runMessage(input string name, input int n, input bit giveLast, input int hold);
        int cnt;
        logMsg.delete();
        logHin.delete();
        applyStimulus(n, giveLast);
        computeModel(n);
        receiveDigest(name, hold, !giveLast && n == MAX_WORDS);
        checkOutput({name, "_blocks"}, logMsg.size(), expBlocks.size());
        cnt = (logMsg.size() < expBlocks.size()) ? logMsg.size() : expBlocks.size();
        for (int k = 0; k < cnt; k++) begin
            checkOutput({name, "_msg"}, logMsg[k], expBlocks[k]);
            checkOutput({name, "_hin"}, logHin[k], expHins[k]);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waitCycles;
        hashT abcdDigest;
        abcdDigest = {32'h6f031589, 32'ha3e16193, 32'h23b9217d, 32'h209c8978,
                      32'hf289579d, 32'h13b845fc, 32'hd4e6338d, 32'h88d4266f};

        repeat (3) @(negedge clk);
        checkOutput("rstMsgReady", msg_ready, 0);
        checkOutput("rstCoreStart", core_start, 0);
        checkOutput("rstDigestValid", digest_valid, 0);
        checkOutput("rstMsgErr", msg_err, 0);
        checkOutput("rstDigest", digest, 0);
        checkOutput("rstCoreMessage", core_message, 0);
        reset = 1'b0;
        coreRst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] single word 0x61626364");
        tbWords.delete();
        tbWords.push_back(32'h61626364);
        runMessage("abcd", 1, 1'b1, 0);
        checkOutput("abcdStarts", logMsg.size(), 1 + DOUBLE);
        if (logMsg.size() > 0) begin
            checkOutput("abcdW0", logMsg[0][0], 32'h61626364);
            checkOutput("abcdW1", logMsg[0][1], 32'h80000000);
            checkOutput("abcdW15", logMsg[0][15], 32'h00000020);
        end
`ifndef SHA256_DOUBLE_EN
        checkOutput("abcdKnownDigest", expDigest, abcdDigest);
`endif

        $display("[TB] 13 words");
        fillRandom(13);
        runMessage("w13", 13, 1'b1, 1);
        checkOutput("w13Starts", logMsg.size(), 1 + DOUBLE);
        if (logMsg.size() > 0) begin
            checkOutput("w13Marker", logMsg[0][13], 32'h80000000);
            checkOutput("w13Len", logMsg[0][15], 32'h000001A0);
        end

        $display("[TB] 14 words");
        fillRandom(14);
        runMessage("w14", 14, 1'b1, 0);
        checkOutput("w14Starts", logMsg.size(), 2 + DOUBLE);
        if (logMsg.size() > 1) begin
            checkOutput("w14Marker", logMsg[0][14], 32'h80000000);
            checkOutput("w14Blk0W15", logMsg[0][15], 32'h0);
            checkOutput("w14Blk1W0", logMsg[1][0], 32'h0);
            checkOutput("w14Len", logMsg[1][15], 32'h000001C0);
        end

        $display("[TB] 16 words");
        fillRandom(16);
        runMessage("w16", 16, 1'b1, 2);
        if (logMsg.size() > 1)
            checkOutput("w16Blk1Marker", logMsg[1][0], 32'h80000000);

        $display("[TB] 20 words");
        fillRandom(20);
        runMessage("w20", 20, 1'b1, 0);
        checkOutput("w20Starts", logMsg.size(), 2 + DOUBLE);
        if (logMsg.size() > 1) begin
            checkOutput("w20Marker", logMsg[1][4], 32'h80000000);
            checkOutput("w20Len", logMsg[1][15], 32'h00000280);
            checkOutput("w20Data3", logMsg[1][3], tbWords[19]);
        end

        $display("[TB] overlong message, no last");
        fillRandom(20);
        runMessage("overflow", 20, 1'b0, 10);

        $display("[TB] next message clears error");
        fillRandom(3);
        runMessage("afterErr", 3, 1'b1, 0);

        $display("[TB] random messages");
        for (int t = 0; t < 10; t++) begin
            int n;
            n = $urandom_range(1, MAX_WORDS);
            fillRandom(n);
            runMessage("rand", n, 1'b1, $urandom_range(0, 3));
        end

        $display("[TB] reset during WAIT_HI");
        logMsg.delete();
        logHin.delete();
        fillRandom(5);
        applyStimulus(5, 1'b1);
        waitCycles = 0;
        while (core_done !== 1'b0 && waitCycles < 200) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("abortCoreBusy", core_done, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("abortDigestValid", digest_valid, 0);
        checkOutput("abortCoreStart", core_start, 0);
        checkOutput("abortMsgReady", msg_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("abortIdleReady", msg_ready, 1);
        repeat (10) @(negedge clk);
        checkOutput("abortNoDigest", digest_valid, 0);
        fillRandom(7);
        runMessage("postAbort", 7, 1'b1, 0);

        checkOutput("coreProtocol", protoErrors, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
